// File: rtl/prim_sync_pkg.sv
// +----------------------------------------------------------------------------+
// | prim_sync_pkg                                                              |
// | Shared limits and counter sizing for the prim_sync_filter family.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package prim_sync_pkg;

    localparam int unsigned c_min_stages        = 2;
    localparam int unsigned c_max_stages        = 4;
    localparam int unsigned c_max_filter_cycles = 255;

    // A bypassed filter still gets a 1-bit width so declarations stay legal.
    function automatic int unsigned cnt_width(input int unsigned filter_cycles);
        if (filter_cycles < 1) begin
            return 1;
        end
        return $clog2(filter_cycles + 1);
    endfunction

endpackage : prim_sync_pkg

`default_nettype wire

// File: rtl/prim_sync_filter_chan.sv
// +----------------------------------------------------------------------------+
// | prim_sync_filter_chan                                                      |
// | One channel: synchroniser chain, glitch filter, optional edge detector.    |
// | Edge logic present only when PRIM_SYNC_FILTER_EDGE_EN is defined.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module prim_sync_filter_chan
    import prim_sync_pkg::*;
#(
    parameter int unsigned Stages       = 2,
    parameter int unsigned FilterCycles = 0,
    parameter logic        ResetValue   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [Stages-1:0] chain_q;
    logic              sync_s;
    logic              w_level;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= {Stages{ResetValue}};
        end else begin
            chain_q <= {chain_q[Stages-2:0], d_i};
        end
    end

    assign sync_s = chain_q[Stages-1];

    if (FilterCycles == 0) begin : g_bypass
        assign w_level = sync_s;
    end else begin : g_filter
        localparam int unsigned   CW     = cnt_width(FilterCycles);
        localparam logic [CW-1:0] c_last = CW'(FilterCycles - 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          level_q;
        logic          level_d;

        // Any cycle of agreement throws away the partial count; ">=" keeps the
        // counter from ever climbing past its terminal value.
        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            if (sync_s == level_q) begin
                cnt_d = '0;
            end else if (cnt_q >= c_last) begin
                level_d = sync_s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q   <= '0;
                level_q <= ResetValue;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign w_level = level_q;
    end

    assign q_o = w_level;

`ifdef PRIM_SYNC_FILTER_EDGE_EN
    logic prev_q;

    // Reset loads the same value as q_o so reset itself never produces a pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= ResetValue;
        end else begin
            prev_q <= w_level;
        end
    end

    assign rise_o = w_level & ~prev_q;
    assign fall_o = ~w_level & prev_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule : prim_sync_filter_chan

`default_nettype wire

// File: rtl/prim_sync_filter.sv
// +----------------------------------------------------------------------------+
// | prim_sync_filter                                                           |
// | Width independent synchronise-and-filter channels with edge pulses.        |
// | Optional macro: PRIM_SYNC_FILTER_EDGE_EN (enables rise_o/fall_o).          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module prim_sync_filter
    import prim_sync_pkg::*;
#(
    parameter int unsigned       Width        = 16,
    parameter int unsigned       Stages       = 2,
    parameter int unsigned       FilterCycles = 0,
    parameter logic [Width-1:0]  ResetValue   = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    if ((Stages < c_min_stages) || (Stages > c_max_stages)) begin : g_bad_stages
        $error("prim_sync_filter: Stages out of range 2..4");
    end

    if (FilterCycles > c_max_filter_cycles) begin : g_bad_filter
        $error("prim_sync_filter: FilterCycles out of range 0..255");
    end

    if (Width < 1) begin : g_bad_width
        $error("prim_sync_filter: Width must be at least 1");
    end

    for (genvar i = 0; i < Width; i++) begin : g_chan
        prim_sync_filter_chan #(
            .Stages       (Stages),
            .FilterCycles (FilterCycles),
            .ResetValue   (ResetValue[i])
        ) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .d_i    (d_i[i]),
            .q_o    (q_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i])
        );
    end

endmodule : prim_sync_filter

`default_nettype wire

// File: tb/tb_prim_sync_filter.sv
// +----------------------------------------------------------------------------+
// | tb_prim_sync_filter                                                        |
// | Scoreboard bench: filtered (4-cycle) and bypassed instances side by side.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_prim_sync_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic [3:0] q0, rise0, fall0;
    logic [3:0] q1, rise1, fall1;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] q;
        logic [3:0] r;
        logic [3:0] f;
        string      name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    prim_sync_filter #(
        .Width(4), .Stages(3), .FilterCycles(4), .ResetValue(4'b0000)
    ) u_dut0 (
        .clk_i(clk), .rst_i(rst), .d_i(d),
        .q_o(q0), .rise_o(rise0), .fall_o(fall0)
    );

    prim_sync_filter #(
        .Width(4), .Stages(3), .FilterCycles(0), .ResetValue(4'b0000)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .d_i(d),
        .q_o(q1), .rise_o(rise1), .fall_o(fall1)
    );

    // Edge outputs are expected only when the edge feature is compiled in.
    function automatic logic [3:0] er(input logic [3:0] x);
`ifdef PRIM_SYNC_FILTER_EDGE_EN
        return x;
`else
        return 4'b0000 & x;
`endif
    endfunction

    function automatic void push(input int off, input int dut, input logic [3:0] q,
                                 input logic [3:0] r, input logic [3:0] f, input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.dut  = dut;
        e.q    = q;
        e.r    = er(r);
        e.f    = er(f);
        e.name = nm;
        sb.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle, retire the scoreboard entries due now.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                if (sb[i].dut == 0) begin
                    chk({sb[i].name, ".q0"}, q0, sb[i].q);
                    chk({sb[i].name, ".rise0"}, rise0, sb[i].r);
                    chk({sb[i].name, ".fall0"}, fall0, sb[i].f);
                end else begin
                    chk({sb[i].name, ".q1"}, q1, sb[i].q);
                    chk({sb[i].name, ".rise1"}, rise1, sb[i].r);
                    chk({sb[i].name, ".fall1"}, fall1, sb[i].f);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        d   = 4'b0000;
        step(3);
        rst = 1'b0;
        push(1, 0, 4'b0000, 4'b0000, 4'b0000, "reset_state");
        push(1, 1, 4'b0000, 4'b0000, 4'b0000, "reset_state");
        step(2);

        // Single channel rises: 7 edges filtered, 3 edges bypassed.
        d = 4'b0001;
        push(6, 0, 4'b0000, 4'b0000, 4'b0000, "ch0_before");
        push(7, 0, 4'b0001, 4'b0001, 4'b0000, "ch0_rise");
        push(8, 0, 4'b0001, 4'b0000, 4'b0000, "ch0_hold");
        push(2, 1, 4'b0000, 4'b0000, 4'b0000, "ch0_byp_before");
        push(3, 1, 4'b0001, 4'b0001, 4'b0000, "ch0_byp_rise");
        push(4, 1, 4'b0001, 4'b0000, 4'b0000, "ch0_byp_hold");
        step(10);

        // Three-cycle glitch on channel 1: rejected by filter, passed by bypass.
        d = 4'b0011;
        push(3, 0, 4'b0001, 4'b0000, 4'b0000, "glitch_a");
        push(6, 0, 4'b0001, 4'b0000, 4'b0000, "glitch_b");
        push(9, 0, 4'b0001, 4'b0000, 4'b0000, "glitch_c");
        push(12, 0, 4'b0001, 4'b0000, 4'b0000, "glitch_d");
        push(3, 1, 4'b0011, 4'b0010, 4'b0000, "glitch_byp_rise");
        push(6, 1, 4'b0001, 4'b0000, 4'b0010, "glitch_byp_fall");
        step(3);
        d = 4'b0001;
        step(12);

        // All channels high, then reset while q_o is all ones.
        d = 4'b1111;
        push(6, 0, 4'b0001, 4'b0000, 4'b0000, "all_before");
        push(7, 0, 4'b1111, 4'b1110, 4'b0000, "all_rise");
        push(3, 1, 4'b1111, 4'b1110, 4'b0000, "all_byp_rise");
        step(10);
        rst = 1'b1;
        push(1, 0, 4'b0000, 4'b0000, 4'b0000, "rst_mid_high");
        push(1, 1, 4'b0000, 4'b0000, 4'b0000, "rst_mid_high");
        step(1);
        rst = 1'b0;
        push(1, 0, 4'b0000, 4'b0000, 4'b0000, "rst_no_fall");
        push(1, 1, 4'b0000, 4'b0000, 4'b0000, "rst_no_fall");
        push(6, 0, 4'b0000, 4'b0000, 4'b0000, "rel_before");
        push(7, 0, 4'b1111, 4'b1111, 4'b0000, "rel_rise");
        push(8, 0, 4'b1111, 4'b0000, 4'b0000, "rel_hold");
        push(2, 1, 4'b0000, 4'b0000, 4'b0000, "rel_byp_before");
        push(3, 1, 4'b1111, 4'b1111, 4'b0000, "rel_byp_rise");
        step(12);

        // Channel 2 toggled every 4 cycles; a 4-cycle pulse just passes the filter.
        d = 4'b1011;
        push(3, 1, 4'b1011, 4'b0000, 4'b0100, "tog_byp_fall1");
        push(6, 0, 4'b1111, 4'b0000, 4'b0000, "tog_before");
        push(7, 0, 4'b1011, 4'b0000, 4'b0100, "tog_fall1");
        push(11, 0, 4'b1111, 4'b0100, 4'b0000, "tog_rise");
        push(15, 0, 4'b1011, 4'b0000, 4'b0100, "tog_fall2");
        step(4);
        d = 4'b1111;
        push(3, 1, 4'b1111, 4'b0100, 4'b0000, "tog_byp_rise");
        step(4);
        d = 4'b1011;
        push(2, 1, 4'b1111, 4'b0000, 4'b0000, "tog_byp_hold");
        push(3, 1, 4'b1011, 4'b0000, 4'b0100, "tog_byp_fall2");

        for (int i = 0; i < 40 && sb.size() > 0; i++) step(1);
        step(1);
        for (int i = 0; i < sb.size(); i++) begin
            total++;
            bad++;
            $display("FAIL %s never checked: due cycle %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prim_sync_filter

`default_nettype wire

// File: doc/prim_sync_filter.md
PRIM_SYNC_FILTER -- requirements
Module: prim_sync_filter

Interface
REQ-001 SHALL have parameter Width, default 16: number of independent single-bit channels.
REQ-002 SHALL have parameter Stages, default 2: synchroniser flop depth per channel, legal range 2..4.
REQ-003 SHALL have parameter FilterCycles, default 0: glitch-filter length in cycles, legal range 0..255; 0 = filter bypassed.
REQ-004 SHALL have parameter ResetValue (logic [Width-1:0]), default '0: reset value of every flop in each channel.
REQ-005 SHALL have port clk_i  input  1: the single clock; all flops on rising edge.
REQ-006 SHALL have port rst_i  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port d_i  input  Width: asynchronous channel inputs.
REQ-008 SHALL have port q_o  output  Width: synchronised, filtered level per channel.
REQ-009 SHALL have port rise_o  output  Width: one-cycle pulse on q_o 0->1 per channel.
REQ-010 SHALL have port fall_o  output  Width: one-cycle pulse on q_o 1->0 per channel.

Function
REQ-011 SHALL pass each d_i bit through a chain of Stages flops; chain output is sync_s; no logic between chain flops.
REQ-012 With FilterCycles=0, q_o SHALL equal sync_s; d_i change sampled at edge N appears on q_o after edge N+Stages-1.
REQ-013 With FilterCycles>0, each channel SHALL hold a counter of width clog2(FilterCycles+1) counting consecutive cycles with sync_s != q_o.
REQ-014 Counter SHALL clear to 0 in any cycle where sync_s == q_o, discarding partial counts (glitch rejected).
REQ-015 When sync_s != q_o and counter == FilterCycles-1, q_o SHALL load sync_s at that edge and counter SHALL clear to 0.
REQ-016 Total latency SHALL be Stages+FilterCycles edges from sampling a stable d_i to q_o change; pulses shorter than FilterCycles sync cycles SHALL never reach q_o.
REQ-017 Counter SHALL saturate, never wrap; no counter value above FilterCycles-1 SHALL be reachable.
REQ-018 rise_o SHALL be high for exactly the one cycle in which q_o first shows 1 after showing 0; fall_o symmetric; never both high on one channel.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-012..018.

Reset
REQ-020 Assertion of rst_i at an edge SHALL load all sync flops and q_o with ResetValue, clear all counters, and force rise_o=fall_o=0 in the following cycle.
REQ-021 Reset mid-filtering SHALL discard the count; no edge pulse SHALL result from reset itself, whatever q_o held before.
REQ-022 First edge pulse after reset release SHALL require a full Stages+FilterCycles of stable differing input.

Configuration
REQ-023 Macro PRIM_SYNC_FILTER_EDGE_EN SHALL compile in the edge-detect logic (previous-q_o register, rise_o/fall_o generation).
REQ-024 Without PRIM_SYNC_FILTER_EDGE_EN, rise_o and fall_o SHALL be tied to 0, no edge register SHALL exist, and q_o behaviour SHALL be unchanged.

Structure
REQ-025 Package prim_sync_pkg SHALL hold the max-Stages and max-FilterCycles constants and the counter-width function.
REQ-026 Per-channel logic SHALL live in sub-module prim_sync_filter_chan (1-bit chain, counter, edge register), instantiated Width times via generate.
REQ-027 Top level SHALL check parameter legality with elaboration-time assertions.

Verification (Width=4, Stages=3, FilterCycles=4, ResetValue=4'b0000, edge feature enabled unless stated)
REQ-028 d_i 4'b0000->4'b0001 held -> q_o[0]=1 exactly 7 edges after sampling edge; rise_o[0] high one cycle; others 0.
REQ-029 d_i[1] high for 3 cycles then low -> q_o[1] stays 0, rise_o[1] never asserts.
REQ-030 d_i=4'b1111 held, then rst_i high one cycle with q_o=4'b1111 -> q_o=4'b0000, no fall_o pulse, then q_o returns to 4'b1111 7 edges after release with four simultaneous rise_o.
REQ-031 FilterCycles=0, d_i[2] toggled every 4 cycles -> q_o[2] follows after 3 edges, alternating rise_o/fall_o pulses.
REQ-032 Macro undefined, same stimulus as REQ-028 -> identical q_o, rise_o and fall_o constant 0.
